// File: rtl/kamus_l1d_if.sv
// kamus_l1d_if: core-side $L1D access port plus backing-memory req/ack port of the L1 data cache
interface kamus_l1d_if;
  logic        l1d_rd_en_i;
  logic        l1d_wr_en_i;
  logic [31:0] l1d_addr_i;
  logic [31:0] l1d_wr_data_i;
  logic [3:0]  l1d_be_i;
  logic [31:0] l1d_rd_data_o;
  logic        l1d_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  modport slave (
    input  l1d_rd_en_i, l1d_wr_en_i, l1d_addr_i, l1d_wr_data_i, l1d_be_i, mem_ack_i, mem_rdata_i,
    output l1d_rd_data_o, l1d_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );
  modport master (
    output l1d_rd_en_i, l1d_wr_en_i, l1d_addr_i, l1d_wr_data_i, l1d_be_i, mem_ack_i, mem_rdata_i,
    input  l1d_rd_data_o, l1d_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );
endinterface

// File: rtl/kamus_l1d.sv
// kamus_l1d: direct-mapped write-through no-write-allocate L1 data cache with line refill over req/ack
module kamus_l1d #(
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4
) (
  input logic         clk_i,
  input logic         rst_ni,
  kamus_l1d_if.slave  bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;
  state_t               state_q, state_d;
  logic [OFF_W-1:0]     cnt_q;
  logic [31:2]          addr_q;
  logic [31:0]          wdata_q;
  logic [3:0]           be_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][LINE_WORDS];
  logic [OFF_W-1:0]     off, q_off;
  logic [IDX_W-1:0]     idx, q_idx;
  logic [TAG_W-1:0]     tag, q_tag;
  logic                 hit, q_hit, last, ack;
  assign off   = bus.l1d_addr_i[2+:OFF_W];
  assign idx   = bus.l1d_addr_i[2+OFF_W+:IDX_W];
  assign tag   = bus.l1d_addr_i[31-:TAG_W];
  assign q_off = addr_q[2+:OFF_W];
  assign q_idx = addr_q[2+OFF_W+:IDX_W];
  assign q_tag = addr_q[31-:TAG_W];
  assign hit   = valid_q[idx] && tag_q[idx] == tag;
  assign q_hit = valid_q[q_idx] && tag_q[q_idx] == q_tag;
  assign ack   = bus.mem_ack_i;
  assign last  = ack && cnt_q == OFF_W'(LINE_WORDS - 1);
  assign bus.l1d_rd_data_o = (bus.l1d_rd_en_i && !bus.l1d_wr_en_i && hit) ? data_q[idx][off] : '0;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d         = state_q;
    bus.l1d_stall_o = 1'b0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.mem_be_o    = '0;
    case (state_q)
      IDLE: begin
        bus.l1d_stall_o = bus.l1d_wr_en_i || (bus.l1d_rd_en_i && !hit);
        state_d = bus.l1d_wr_en_i ? WRITE : (bus.l1d_rd_en_i && !hit) ? REFILL : IDLE;
      end
      REFILL: begin
        bus.l1d_stall_o = 1'b1;
        bus.mem_req_o   = 1'b1;
        bus.mem_addr_o  = {addr_q[31:2+OFF_W], cnt_q, 2'b00};
        state_d = last ? IDLE : REFILL;
      end
      default: begin
        bus.l1d_stall_o = !ack;
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = {addr_q, 2'b00};
        bus.mem_wdata_o = wdata_q;
        bus.mem_be_o    = be_q;
        state_d = ack ? IDLE : WRITE;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      valid_q <= '0;
    end else if (state_q == IDLE && (bus.l1d_rd_en_i || bus.l1d_wr_en_i)) begin
      cnt_q   <= '0;
      addr_q  <= bus.l1d_addr_i[31:2];
      wdata_q <= bus.l1d_wr_data_i;
      be_q    <= bus.l1d_be_i;
    end else if (state_q == REFILL && ack) begin
      cnt_q <= cnt_q + 1'b1;
      if (last) valid_q[q_idx] <= 1'b1;
    end
  always_ff @(posedge clk_i)
    if (state_q == REFILL && ack) begin
      data_q[q_idx][cnt_q] <= bus.mem_rdata_i;
      if (last) tag_q[q_idx] <= q_tag;
    end else if (state_q == WRITE && ack && q_hit) begin
      for (int b = 0; b < 4; b++)
        if (be_q[b]) data_q[q_idx][q_off][8*b+:8] <= wdata_q[8*b+:8];
    end
endmodule

// File: tb/tb_kamus_l1d.sv
// tb_kamus_l1d: directed and randomized checks of kamus_l1d against a word-memory plus resident-tag model
module tb_kamus_l1d;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;
  kamus_l1d_if bus();
  kamus_l1d dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [int unsigned];
  logic        m_valid [64];
  logic [31:0] m_tag [64];
  function automatic logic [31:0] rdmem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ((a * 32'h9E3779B1) ^ 32'h5A5A0000);
  endfunction
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask
  task automatic chk_mem(input string t, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    chk({t, "_req"}, 32'(bus.mem_req_o), 1);
    chk({t, "_we"}, 32'(bus.mem_we_o), 32'(we));
    chk({t, "_addr"}, bus.mem_addr_o, a);
    chk({t, "_stall"}, 32'(bus.l1d_stall_o), 1);
    if (we) begin
      chk({t, "_wdata"}, bus.mem_wdata_o, d);
      chk({t, "_be"}, 32'(bus.mem_be_o), 32'(be));
    end
  endtask
  task automatic rd(input logic [31:0] a, input int dly, output logic missed, output logic [31:0] q);
    logic [31:0] base;
    int idx;
    base = a & ~32'hF;
    idx = int'((a >> 4) & 63);
    missed = !(m_valid[idx] && m_tag[idx] == (a >> 10));
    bus.l1d_rd_en_i = 1'b1;
    bus.l1d_wr_en_i = 1'b0;
    bus.l1d_addr_i = a;
    #1;
    chk("rd_stall", 32'(bus.l1d_stall_o), 32'(missed));
    q = bus.l1d_rd_data_o;
    if (missed) begin
      chk("rd_miss_data", bus.l1d_rd_data_o, 0);
      chk("rd_idle_req", 32'(bus.mem_req_o), 0);
      @(negedge clk_i);
      for (int w = 0; w < 4; w++) begin
        for (int d = 0; d < dly; d++) begin
          #1 chk_mem("refill_wait", 1'b0, base + 32'(4 * w), 0, 0);
          @(negedge clk_i);
        end
        bus.mem_ack_i = 1'b1;
        bus.mem_rdata_i = rdmem(base + 32'(4 * w));
        #1 chk_mem("refill_ack", 1'b0, base + 32'(4 * w), 0, 0);
        @(negedge clk_i);
        bus.mem_ack_i = 1'b0;
        bus.mem_rdata_i = $urandom;
      end
      m_valid[idx] = 1'b1;
      m_tag[idx] = a >> 10;
      #1;
      chk("rd_refilled_stall", 32'(bus.l1d_stall_o), 0);
      chk("rd_refilled_req", 32'(bus.mem_req_o), 0);
      q = bus.l1d_rd_data_o;
    end
    chk("rd_data", q, rdmem(a));
    @(negedge clk_i);
    bus.l1d_rd_en_i = 1'b0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input int dly);
    logic [31:0] v;
    bus.l1d_wr_en_i = 1'b1;
    bus.l1d_rd_en_i = 1'b0;
    bus.l1d_addr_i = a;
    bus.l1d_wr_data_i = d;
    bus.l1d_be_i = be;
    #1;
    chk("wr_issue_stall", 32'(bus.l1d_stall_o), 1);
    chk("wr_issue_req", 32'(bus.mem_req_o), 0);
    @(negedge clk_i);
    for (int i = 0; i < dly; i++) begin
      #1 chk_mem("wr_wait", 1'b1, a & ~32'h3, d, be);
      @(negedge clk_i);
    end
    bus.mem_ack_i = 1'b1;
    #1;
    chk("wr_ack_req", 32'(bus.mem_req_o), 1);
    chk("wr_ack_addr", bus.mem_addr_o, a & ~32'h3);
    chk("wr_ack_stall", 32'(bus.l1d_stall_o), 0);
    @(negedge clk_i);
    bus.mem_ack_i = 1'b0;
    bus.l1d_wr_en_i = 1'b0;
    v = rdmem(a & ~32'h3);
    for (int b = 0; b < 4; b++) if (be[b]) v[8*b+:8] = d[8*b+:8];
    mem[a & ~32'h3] = v;
  endtask
  initial begin
    logic m;
    logic [31:0] q, a;
    bus.l1d_rd_en_i = 1'b0;
    bus.l1d_wr_en_i = 1'b0;
    bus.l1d_addr_i = '0;
    bus.l1d_wr_data_i = '0;
    bus.l1d_be_i = '0;
    bus.mem_ack_i = 1'b0;
    bus.mem_rdata_i = '0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_req", 32'(bus.mem_req_o), 0);
    chk("rst_we", 32'(bus.mem_we_o), 0);
    chk("rst_addr", bus.mem_addr_o, 0);
    chk("rst_wdata", bus.mem_wdata_o, 0);
    chk("rst_be", 32'(bus.mem_be_o), 0);
    chk("rst_rdata", bus.l1d_rd_data_o, 0);
    chk("rst_stall", 32'(bus.l1d_stall_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    rd(32'h100, 0, m, q);
    chk("t1_miss", 32'(m), 1);
    chk("t1_data", q, 32'hA0);
    rd(32'h10C, 0, m, q);
    chk("t1_hit", 32'(m), 0);
    chk("t1_hit_data", q, 32'hA3);
    wr(32'h104, 32'h11223344, 4'hF, 0);
    wr(32'h104, 32'hAABBCCDD, 4'b0011, 2);
    rd(32'h104, 0, m, q);
    chk("t2_hit", 32'(m), 0);
    chk("t2_merge", q, 32'h1122CCDD);
    wr(32'h104, 32'hFFFFFFFF, 4'b0000, 0);
    rd(32'h104, 0, m, q);
    chk("be0_unchanged", q, 32'h1122CCDD);
    wr(32'h2000, 32'h0BADF00D, 4'hF, 1);
    rd(32'h2000, 0, m, q);
    chk("t3_no_alloc", 32'(m), 1);
    chk("t3_data", q, 32'h0BADF00D);
    rd(32'h500, 0, m, q);
    chk("t4_evict_miss", 32'(m), 1);
    rd(32'h100, 0, m, q);
    chk("t4_reread_miss", 32'(m), 1);
    rd(32'h508, 5, m, q);
    chk("t5_refill_hold", 32'(m), 1);
    wr(32'h508, 32'h12345678, 4'b1010, 5);
    bus.mem_ack_i = 1'b1;
    #1 chk("idle_ack_req", 32'(bus.mem_req_o), 0);
    @(negedge clk_i);
    bus.mem_ack_i = 1'b0;
    rd(32'h508, 0, m, q);
    chk("stray_ack_hit", 32'(m), 0);
    bus.l1d_rd_en_i = 1'b1;
    bus.l1d_addr_i = 32'h100;
    @(negedge clk_i);
    for (int w = 0; w < 2; w++) begin
      bus.mem_ack_i = 1'b1;
      bus.mem_rdata_i = rdmem(32'h500 + 32'(4 * w));
      @(negedge clk_i);
      bus.mem_ack_i = 1'b0;
    end
    #1 chk("t6_refill_in_progress", 32'(bus.mem_req_o), 1);
    rst_ni = 1'b0;
    bus.l1d_rd_en_i = 1'b0;
    #1;
    chk("t6_rst_req", 32'(bus.mem_req_o), 0);
    chk("t6_rst_stall", 32'(bus.l1d_stall_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    rd(32'h2000, 0, m, q);
    chk("t6_other_invalid", 32'(m), 1);
    rd(32'h100, 1, m, q);
    chk("t6_refill_again", 32'(m), 1);
    for (int n = 0; n < 300; n++) begin
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 2) == 0) wr(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
      else rd(a, $urandom_range(0, 2), m, q);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
